// File: rtl/deserializer.sv
// Serial-to-parallel receiver: LSB-first frames started by a sync strobe.
// Completed words are held in data with a Wen/rd handshake.
module deserializer #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_bit,
  input  logic                 in_valid,
  input  logic                 sync,
  input  logic                 rd,
  output logic [DATA_SIZE-1:0] data,
  output logic                 Wen,
  output logic                 overrun,
  output logic                 abort
);

  localparam int AW = DATA_SIZE - 1;
  localparam int CW = $clog2(DATA_SIZE + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic                   wen_q, wen_d;
  logic                   overrun_q, overrun_d;
  logic                   abort_q, abort_d;

  // acc only ever holds the first DATA_SIZE-1 bits; the last bit
  // goes straight into data together with acc.
  logic [AW-1:0]          acc_shift;
  logic [AW-1:0]          acc_first;
  logic [DATA_SIZE-1:0]   word;
  logic                   last;

  assign acc_shift = AW'({in_bit, acc_q} >> 1);
  assign acc_first = AW'({in_bit, {AW{1'b0}}} >> 1);
  assign word      = {in_bit, acc_q};
  assign last      = (cnt_q == CW'(DATA_SIZE - 1));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    wen_d     = wen_q & ~rd;
    overrun_d = overrun_q;
    abort_d   = 1'b0;
    if (in_valid) begin
      if (sync) begin
        acc_d   = acc_first;
        cnt_d   = CW'(1);
        state_d = SHIFT;
        abort_d = (state_q == SHIFT);
      end else if (state_q == SHIFT) begin
        if (last) begin
          data_d    = word;
          wen_d     = 1'b1;
          overrun_d = overrun_q | (wen_q & ~rd);
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          acc_d = acc_shift;
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      wen_q     <= 1'b0;
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      wen_q     <= wen_d;
      overrun_q <= overrun_d;
      abort_q   <= abort_d;
    end
  end

  assign data    = data_q;
  assign Wen     = wen_q;
  assign overrun = overrun_q;
  assign abort   = abort_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer at DATA_SIZE=32.
// Inputs change and outputs are checked on the falling edge.
module tb_deserializer;

  logic        clk;
  logic        rst;
  logic        in_bit;
  logic        in_valid;
  logic        sync;
  logic        rd;
  logic [31:0] data;
  logic        Wen;
  logic        overrun;
  logic        abort;

  int checks;
  int errors;
  int abort_cnt;
  int a0;

  deserializer #(.DATA_SIZE(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .sync     (sync),
    .rd       (rd),
    .data     (data),
    .Wen      (Wen),
    .overrun  (overrun),
    .abort    (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (abort === 1'b1) abort_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input logic s = 1'bx);
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'bx;
    sync     = s;
    rd       = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic s,
                          input logic r = 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = b;
    sync     = s;
    rd       = r;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps = 0,
                           input logic rd_last = 1'b0);
    for (int i = 0; i < 32; i++) begin
      send_bit(w[i], i == 0, (i == 31) ? rd_last : 1'b0);
      if (gaps && i != 31) repeat ($urandom_range(0, 5)) idle();
    end
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'bx;
    sync     = 1'bx;
    rd       = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rd       = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    abort_cnt = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    sync      = 1'b0;
    rd        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 32'h0);
    chk("rst_wen", {31'b0, Wen}, 32'h0);
    chk("rst_ovr", {31'b0, overrun}, 32'h0);
    chk("rst_abort", {31'b0, abort}, 32'h0);
    rst = 1'b1;

    send_word(32'hA5C30F81);
    idle();
    chk("basic_data", data, 32'hA5C30F81);
    chk("basic_wen", {31'b0, Wen}, 32'h1);
    pulse_rd();
    chk("basic_rd_wen", {31'b0, Wen}, 32'h0);

    a0 = abort_cnt;
    send_word(32'hA5C30F81, 1);
    idle();
    chk("gap_data", data, 32'hA5C30F81);
    chk("gap_wen", {31'b0, Wen}, 32'h1);
    chk("gap_abort", abort_cnt - a0, 0);
    pulse_rd();

    send_word(32'h00000001);
    send_word(32'hFFFFFFFF);
    idle();
    chk("b2b_data", data, 32'hFFFFFFFF);
    chk("b2b_wen", {31'b0, Wen}, 32'h1);
    chk("b2b_ovr", {31'b0, overrun}, 32'h1);
    idle();
    chk("ovr_sticky", {31'b0, overrun}, 32'h1);

    do_reset();
    chk("ovr_cleared", {31'b0, overrun}, 32'h0);
    send_word(32'h00000001);
    send_word(32'hFFFFFFFF, 0, 1'b1);
    idle();
    chk("rdsame_data", data, 32'hFFFFFFFF);
    chk("rdsame_wen", {31'b0, Wen}, 32'h1);
    chk("rdsame_ovr", {31'b0, overrun}, 32'h0);
    pulse_rd();
    chk("rdsame_rd_wen", {31'b0, Wen}, 32'h0);

    a0 = abort_cnt;
    for (int i = 0; i < 10; i++) send_bit(1'b1, i == 0);
    send_word(32'h12345678);
    idle();
    chk("resync_abort", abort_cnt - a0, 1);
    chk("resync_data", data, 32'h12345678);
    chk("resync_wen", {31'b0, Wen}, 32'h1);

    for (int i = 0; i < 16; i++) send_bit(1'b1, i == 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    chk("arst_data", data, 32'h0);
    chk("arst_wen", {31'b0, Wen}, 32'h0);
    chk("arst_ovr", {31'b0, overrun}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b0);
    idle();
    chk("post_rst_wen", {31'b0, Wen}, 32'h0);
    chk("post_rst_data", data, 32'h0);
    send_word(32'hDEADBEEF);
    idle();
    chk("post_rst_frame", data, 32'hDEADBEEF);
    chk("post_rst_fwen", {31'b0, Wen}, 32'h1);
    pulse_rd();

    a0 = abort_cnt;
    for (int i = 0; i < 40; i++) send_bit(i[0], 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle();
    chk("idle_wen", {31'b0, Wen}, 32'h0);
    chk("idle_data", data, 32'hDEADBEEF);
    send_word(32'h5A5A1234);
    idle();
    chk("idle_then_frame", data, 32'h5A5A1234);
    chk("idle_no_abort", abort_cnt - a0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
